// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst reader and its local queue.
package fifo_burst_reader_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned BURST_LEN_DEF = 16;
  localparam int unsigned BUF_DEPTH_DEF = 4;
  // Pointer carries one extra wrap bit so full and empty are distinguishable
  localparam int unsigned PTR_W_DEF     = $clog2(BUF_DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_sync_queue.sv
// Single-clock circular buffer; head word is read straight from the storage registers.
module fifo_burst_reader_sync_queue
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int unsigned PTR_W     = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W-1:0]  occ
);

  localparam int unsigned AW = PTR_W - 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage is cleared on reset so the output word reads zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign dout = mem[rd_ptr[AW-1:0]];
  assign occ  = wr_ptr - rd_ptr;

endmodule

// File: rtl/fifo_burst_reader.sv
// FIFO read-side consumer: credit-limited pops, local latency queue, burst framing.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy,
  output logic [15:0]       burst_cnt
);

  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned CRED_W = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state;
  state_t              state_nxt;
  logic                inflight;
  logic [PTR_W-1:0]    occ;
  logic [BEAT_W-1:0]   beat;
  logic                pop;
  logic                credit_ok;

  // Words already queued plus the one still in the FIFO read pipeline must fit
  assign credit_ok = (CRED_W'(occ) + CRED_W'(inflight)) < CRED_W'(BUF_DEPTH);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN:   if (!en) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_nxt = ST_RUN;
        end else if ((occ == '0) && !inflight) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_RUN: begin
        fifo_rd_en = !fifo_empty && credit_ok;
        busy       = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      default:  ;
    endcase
  end

  // FIFO data_out is valid one cycle after the pop request
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  fifo_burst_reader_sync_queue #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .PTR_W     (PTR_W)
  ) u_sync_queue (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_data),
    .dout  (m_data),
    .occ   (occ)
  );

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign m_sop   = m_valid && (beat == '0);
  assign m_eop   = m_valid && (beat == LAST_BEAT);

  // Beat position survives enable toggles and FIFO underrun; only reset clears it
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      burst_cnt <= '0;
    end else if (pop) begin
      if (beat == LAST_BEAT) begin
        beat      <= '0;
        burst_cnt <= burst_cnt + 16'(1);
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side consumer for the dual-clock FIFO, running entirely in the FIFO read clock domain. It pops words from the FIFO read port with a credit-limited request stream that never over-reads. It buffers the 1-cycle read latency in a small local queue and presents the words as a valid/ready stream. The stream is framed into fixed-length bursts with start/end markers for the downstream packer.

Parameters:
DATA_W, 16, word width; matches FIFO data_out.
BURST_LEN, 16, beats per burst; must be 2 or more.
BUF_DEPTH, 4, local output queue entries; power of two, 4 or more.

Ports:
rd_clk  input  1  read-domain clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable; 0 stops new FIFO reads, buffered data still drains.
fifo_empty  input  1  FIFO empty flag (rd_clk domain).
fifo_rd_en  output  1  FIFO pop request.
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accept.
m_data  output  DATA_W  output word.
m_sop  output  1  first beat of burst; qualified by m_valid.
m_eop  output  1  last beat of burst; qualified by m_valid.
busy  output  1  state is not IDLE.
burst_cnt  output  16  completed bursts (eop handshakes); wraps at 65535.

Behaviour:
- Reset, async assert, sync release: fifo_rd_en=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, busy=0, burst_cnt=0, queue empty, in-flight flag 0, beat counter 0, state IDLE.
- Handshake: a beat transfers when m_valid && m_ready. While m_valid=1 and m_ready=0, m_data/m_sop/m_eop hold stable.
- Read issue (combinational, registered fifo_rd_en not required): fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - occ is the queue count. inflight is 1 if fifo_rd_en was high last cycle.
  - Never asserted while fifo_empty=1. Never overflows the queue.
- Latency: fifo_rd_en high in cycle N -> fifo_data captured at end of N+1 -> m_valid=1 in cycle N+2 at the earliest.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and m_ready=1.
- Queue: circular buffer with ptr width log2(BUF_DEPTH)+1. Simultaneous push and pop in the same cycle leaves occ unchanged. m_data comes from a registered head.
- Framing: beat counter 0..BURST_LEN-1 advances on each handshake and wraps to 0.
  - m_sop = (beat==0), m_eop = (beat==BURST_LEN-1).
  - burst_cnt increments on an eop handshake.
  - Beat position persists across en toggles. Cleared only by reset.
- FSM:
  - IDLE: busy=0. Goes to RUN when en=1.
  - RUN: issues reads. Goes to DRAIN when en=0.
  - DRAIN: no new reads. The in-flight word is still captured. Goes to IDLE when occ==0 && inflight==0. If en returns to 1, goes back to RUN immediately.
- Boundary cases:
  - FIFO goes empty mid-burst: m_valid drops after the queue drains. The burst resumes at the same beat index with no sop reinsertion.
  - fifo_empty rising in the same cycle as a read decision: the read is suppressed that cycle.
  - Queue full and m_ready=0: fifo_rd_en=0 until a pop frees a credit.
  - Reset mid-burst: all state clears. The partially read burst is lost and the next beat is sop.

Decomposition:
- Shared package: DATA_W default, and a localparam for ceil-log2 pointer width.
- FSM state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One sub-module: sync_queue. Single-clock circular buffer, parameters DATA_W and BUF_DEPTH, ports push/pop/din/dout/occ.
- The top holds the FSM, credit logic and framing.

Test Plan:
1. FIFO model holds words 0..39, en=1, m_ready=1 -> m_data 0..39 in order at 1/cycle after 2-cycle latency. sop on 0,16,32; eop on 15,31. burst_cnt=2. After drain, busy=1 until en=0.
2. FIFO holds 100 words, m_ready toggles 1,0 each cycle -> no gaps in data sequence, outputs held while stalled. fifo_rd_en never high when occ+inflight=4. No lost or duplicated word.
3. m_ready=0 for 20 cycles with the FIFO full -> exactly 4 reads, then fifo_rd_en=0. Releasing m_ready resumes with word 0 first.
4. FIFO holds 10 words, then refilled with 10..25 after 30 cycles -> word 10 is beat 10 (no sop). eop on word 15. burst_cnt=1.
5. Drop en after word 5 is issued -> words up to the last in-flight are delivered, then IDLE with no further fifo_rd_en. Re-raising en continues the sequence with no gap.
6. Assert rst_n=0 mid-burst at beat 7 -> all outputs 0 within the same cycle. After release with en=1, the next word carries m_sop=1 and burst_cnt=0.
